// File: rtl/stepper_move_ctrl.sv
// Move controller: takes a step-count/direction command and emits spaced one-cycle step pulses.
// Latency: first pulse `period` cycles after the accept edge; pulses are registered.
// Backpressure: cmd_ready is high only in IDLE; abort ends a move on the next edge.
// Build option STEPPER_RAMP_EN: trapezoidal ramp between START_PERIOD and MIN_PERIOD.
// Without it every pulse is MIN_PERIOD apart.
module stepper_move_ctrl #(
    parameter int STEPS_W      = 16,
    parameter int CNT_W        = 21,
    parameter int START_PERIOD = 1000000,
    parameter int MIN_PERIOD   = 500000,
    parameter int RAMP_DEC     = 50000
) (
    input  logic               CLK50MHZ,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               cmd_dir,
    input  logic               abort,
    output logic               step_pulse,
    output logic               step_dir,
    output logic               busy,
    output logic [STEPS_W-1:0] steps_left
);

    localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
`ifdef STEPPER_RAMP_EN
    localparam logic [CNT_W-1:0] DEC_P   = CNT_W'(RAMP_DEC);
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic               pulse_q, pulse_d;
    logic               dir_q, dir_d;
    logic [STEPS_W-1:0] left_q, left_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [STEPS_W-1:0] left_dec;
`ifdef STEPPER_RAMP_EN
    logic [STEPS_W-1:0] ramp_q, ramp_d;
`endif

    assign left_dec = left_q - 1'b1;

    // Handshake and status outputs; ready is masked while reset is held.
    assign cmd_ready  = resetn && (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign step_pulse = pulse_q;
    assign step_dir   = dir_q;
    assign steps_left = left_q;

    // Next-state: command accept, period timing, pulse generation, ramp update, abort.
    always_comb begin
        state_d  = state_q;
        pulse_d  = 1'b0;
        dir_d    = dir_q;
        left_d   = left_q;
        timer_d  = timer_q;
        period_d = period_q;
`ifdef STEPPER_RAMP_EN
        ramp_d   = ramp_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A zero-length command is consumed without starting a move.
                if (cmd_valid && (cmd_steps != '0)) begin
                    state_d = S_RUN;
                    left_d  = cmd_steps;
                    dir_d   = cmd_dir;
                    timer_d = '0;
`ifdef STEPPER_RAMP_EN
                    period_d = START_P;
                    ramp_d   = '0;
`else
                    period_d = MIN_P;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Any pulse due on this edge is dropped.
                    state_d = S_IDLE;
                    left_d  = '0;
                    timer_d = '0;
                end else if (timer_q == period_q - 1'b1) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                    left_d  = left_dec;
                    if (left_q == STEPS_W'(1)) begin
                        state_d = S_IDLE;
                    end
`ifdef STEPPER_RAMP_EN
                    // Accelerate while more steps remain than were spent ramping up,
                    // decelerate once the remaining steps match the ramp length.
                    if ((left_dec > ramp_q) && (period_q > MIN_P)) begin
                        period_d = ((period_q - MIN_P) > DEC_P) ? (period_q - DEC_P) : MIN_P;
                        ramp_d   = ramp_q + 1'b1;
                    end else if ((left_dec <= ramp_q) && (ramp_q != '0)) begin
                        period_d = ((START_P - period_q) > DEC_P) ? (period_q + DEC_P) : START_P;
                        ramp_d   = ramp_q - 1'b1;
                    end
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK50MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pulse_q  <= 1'b0;
            dir_q    <= 1'b0;
            left_q   <= '0;
            timer_q  <= '0;
            period_q <= START_P;
`ifdef STEPPER_RAMP_EN
            ramp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            dir_q    <= dir_d;
            left_q   <= left_d;
            timer_q  <= timer_d;
            period_q <= period_d;
`ifdef STEPPER_RAMP_EN
            ramp_q   <= ramp_d;
`endif
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl with small timing parameters.
// A schedule model predicts every pulse time from the move rules; outputs are checked each cycle.
// Directed moves cover ramp, cruise, abort, zero-length, back-to-back and mid-move reset.
module tb_stepper_move_ctrl;

    localparam int STEPS_W = 16;
    localparam int START   = 10;
    localparam int MINP    = 4;
    localparam int DEC     = 2;

    logic               clk = 1'b0;
    logic               resetn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_dir;
    logic               abort;
    logic               step_pulse;
    logic               step_dir;
    logic               busy;
    logic [STEPS_W-1:0] steps_left;

    stepper_move_ctrl #(
        .STEPS_W(STEPS_W), .CNT_W(8), .START_PERIOD(START),
        .MIN_PERIOD(MINP), .RAMP_DEC(DEC)
    ) dut (
        .CLK50MHZ(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort),
        .step_pulse(step_pulse), .step_dir(step_dir), .busy(busy), .steps_left(steps_left)
    );

    initial forever #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    bit  run_chk = 1'b0;

    // model state
    bit  m_busy = 1'b0;
    bit  m_dir = 1'b0;
    bit  m_pulse = 1'b0;
    int  m_steps = 0;
    int  m_accepts = 0;
    int  m_acc_cyc = 0;
    int  m_pulses = 0;
    int  sched[$];
    int  mgaps[$];

    // observed DUT pulses (cycle numbers)
    int  dut_pcyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Schedule model: on accept, lay out absolute pulse times from the ramp rules.
    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_busy  = 1'b0;
            m_dir   = 1'b0;
            m_pulse = 1'b0;
            m_steps = 0;
            sched.delete();
        end else begin
            cyc++;
            m_pulse = 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy  = 1'b0;
                    m_steps = 0;
                    sched.delete();
                end else if (sched.size() > 0 && sched[0] == cyc) begin
                    void'(sched.pop_front());
                    m_steps--;
                    m_pulses++;
                    m_pulse = 1'b1;
                    if (m_steps == 0) m_busy = 1'b0;
                end
            end else if (cmd_valid) begin
                m_accepts++;
                m_acc_cyc = cyc;
                if (cmd_steps != 0) begin
                    int per, rc, t, n;
                    n = int'(cmd_steps);
`ifdef STEPPER_RAMP_EN
                    per = START;
`else
                    per = MINP;
`endif
                    rc = 0;
                    t  = cyc;
                    mgaps.delete();
                    for (int k = 1; k <= n; k++) begin
                        t += per;
                        sched.push_back(t);
                        mgaps.push_back(per);
`ifdef STEPPER_RAMP_EN
                        if ((n - k) > rc && per > MINP) begin
                            per = (per - DEC < MINP) ? MINP : per - DEC;
                            rc++;
                        end else if ((n - k) <= rc && rc > 0) begin
                            per = (per + DEC > START) ? START : per + DEC;
                            rc--;
                        end
`endif
                    end
                    m_busy  = 1'b1;
                    m_dir   = cmd_dir;
                    m_steps = n;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    initial forever begin
        @(negedge clk);
        if (resetn && run_chk) begin
            if (step_pulse === 1'b1) dut_pcyc.push_back(cyc);
            chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("cmd_ready",  32'(cmd_ready),  32'(!m_busy));
            chk("steps_left", 32'(steps_left), 32'(m_steps));
            chk("step_dir",   32'(step_dir),   32'(m_dir));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int steps, input bit dir);
        int n0, n;
        n0 = m_accepts;
        n  = 0;
        cmd_valid = 1'b1;
        cmd_steps = STEPS_W'(steps);
        cmd_dir   = dir;
        while (m_accepts == n0 && n < 300) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("accept_timeout", 32'(m_accepts > n0), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (m_busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    int exp5[5];
    int i0, a0, prev, sum, mn, n, p0;

    initial begin
`ifdef STEPPER_RAMP_EN
        exp5 = '{10, 8, 6, 8, 10};
`else
        exp5 = '{4, 4, 4, 4, 4};
`endif
        resetn = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
        repeat (3) tick();
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(cmd_ready),  32'd0);
        chk("rst_left",  32'(steps_left), 32'd0);
        chk("rst_dir",   32'(step_dir),   32'd0);
        resetn = 1'b1;
        tick();
        run_chk = 1'b1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy",  32'(busy),      32'd0);

        // 5-step move: gaps pinned to hand-computed values
        i0 = dut_pcyc.size();
        send(5, 1'b1);
        a0 = m_acc_cyc;
        wait_idle(400);
        tick();
        chk("n5_pulses", 32'(dut_pcyc.size() - i0), 32'd5);
        prev = a0;
        for (int k = 0; k < 5 && (i0 + k) < dut_pcyc.size(); k++) begin
            chk("gap5_dut", 32'(dut_pcyc[i0 + k] - prev), 32'(exp5[k]));
            chk("gap5_model", 32'(mgaps[k]), 32'(exp5[k]));
            prev = dut_pcyc[i0 + k];
        end

        // 20-step move: total duration and period floor
        i0 = dut_pcyc.size();
        send(20, 1'b0);
        a0 = m_acc_cyc;
        wait_idle(1000);
        tick();
        chk("n20_pulses", 32'(dut_pcyc.size() - i0), 32'd20);
        prev = a0; sum = 0; mn = 1000;
        for (int k = i0; k < dut_pcyc.size(); k++) begin
            sum += dut_pcyc[k] - prev;
            if (dut_pcyc[k] - prev < mn) mn = dut_pcyc[k] - prev;
            prev = dut_pcyc[k];
        end
`ifdef STEPPER_RAMP_EN
        chk("n20_duration", 32'(sum), 32'd104);
`else
        chk("n20_duration", 32'(sum), 32'd80);
`endif
        chk("n20_floor", 32'(mn >= MINP), 32'd1);

        // abort 3 cycles after pulse 2 of an 8-step move
        i0 = dut_pcyc.size();
        p0 = m_pulses;
        send(8, 1'b1);
        n = 0;
        while (m_pulses < p0 + 2 && n < 300) begin
            tick();
            n++;
        end
        chk("abort_wait_p2", 32'(m_pulses - p0), 32'd2);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_left",  32'(steps_left), 32'd0);
        chk("abort_ready", 32'(cmd_ready),  32'd1);
        repeat (15) tick();
        chk("abort_pulses", 32'(dut_pcyc.size() - i0), 32'd2);

        // abort while idle is ignored; zero-length command accepted with no move
        abort = 1'b1;
        send(0, 1'b0);
        abort = 1'b0;
        tick();
        chk("zero_busy",  32'(busy),      32'd0);
        chk("zero_ready", 32'(cmd_ready), 32'd1);
        chk("zero_dir",   32'(step_dir),  32'd1);

        // back-to-back: second command held through the first move
        i0 = dut_pcyc.size();
        send(3, 1'b1);
        p0 = m_accepts;
        cmd_valid = 1'b1;
        cmd_steps = STEPS_W'(2);
        cmd_dir   = 1'b0;
        n = 0;
        while (m_accepts == p0 && n < 300) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accept_cyc", 32'(m_acc_cyc), 32'(((i0 + 2) < dut_pcyc.size()) ? dut_pcyc[i0 + 2] + 1 : -1));
        chk("b2b_reload", 32'(steps_left), 32'd2);
        wait_idle(400);
        tick();
        chk("b2b_pulses", 32'(dut_pcyc.size() - i0), 32'd5);
        chk("b2b_dir",    32'(step_dir),              32'd0);

        // reset in the middle of a move
        send(6, 1'b1);
        repeat (5) tick();
        run_chk = 1'b0;
        resetn  = 1'b0;
        #1;
        chk("mid_rst_pulse", 32'(step_pulse), 32'd0);
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_left",  32'(steps_left), 32'd0);
        chk("mid_rst_dir",   32'(step_dir),   32'd0);
        chk("mid_rst_ready", 32'(cmd_ready),  32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run_chk = 1'b1;
        chk("mid_rst_rel_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rel_busy",  32'(busy),      32'd0);
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
